// File: rtl/lstm_pkg.sv
// Shared types and constants for the LSTM parameter-load and inference sequencer.
package lstm_pkg;

  localparam logic [2:0] T_SYS_W = 3'd0;
  localparam logic [2:0] T_SYS_B = 3'd1;
  localparam logic [2:0] T_BR_W  = 3'd2;
  localparam logic [2:0] T_BR_B  = 3'd3;
  localparam logic [2:0] T_CV_W  = 3'd4;
  localparam logic [2:0] T_CV_B  = 3'd5;
  localparam logic [2:0] T_IDLE  = 3'd7;

  // Segment index one past the last segment: load complete.
  localparam logic [2:0] SEG_END = 3'd6;

  localparam int unsigned DEF_SYS_W_LEN = 512;
  localparam int unsigned DEF_SYS_B_LEN = 32;
  localparam int unsigned DEF_BR_W_LEN  = 32768;
  localparam int unsigned DEF_BR_B_LEN  = 256;
  localparam int unsigned DEF_CV_W_LEN  = 1024;
  localparam int unsigned DEF_CV_B_LEN  = 128;

  // BUSY cycles before a silent core gets a fresh next pulse.
  localparam logic [2:0] RETRY_LAST = 3'd6;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PUSH,
    S_GAP,
    S_RUN,
    S_ISSUE,
    S_BUSY,
    S_DONE,
    S_OUT
  } state_e;

endpackage

// File: rtl/seg_len_rom.sv
// Segment length lookup: length of seg_i, empty flag, and the
// next non-empty segment after seg_i (SEG_END when none is left).
module seg_len_rom
  import lstm_pkg::*;
#(
  parameter int unsigned SYS_W_LEN = DEF_SYS_W_LEN,
  parameter int unsigned SYS_B_LEN = DEF_SYS_B_LEN,
  parameter int unsigned BR_W_LEN  = DEF_BR_W_LEN,
  parameter int unsigned BR_B_LEN  = DEF_BR_B_LEN,
  parameter int unsigned CV_W_LEN  = DEF_CV_W_LEN,
  parameter int unsigned CV_B_LEN  = DEF_CV_B_LEN
) (
  input  logic [2:0]  seg_i,
  output logic [16:0] len_o,
  output logic        zero_o,
  output logic [2:0]  next_o
);

  localparam int unsigned LENS [6] = '{
    SYS_W_LEN, SYS_B_LEN, BR_W_LEN,
    BR_B_LEN, CV_W_LEN, CV_B_LEN
  };

  always_comb begin
    len_o = '0;
    case (seg_i)
      T_SYS_W: len_o = 17'(SYS_W_LEN);
      T_SYS_B: len_o = 17'(SYS_B_LEN);
      T_BR_W:  len_o = 17'(BR_W_LEN);
      T_BR_B:  len_o = 17'(BR_B_LEN);
      T_CV_W:  len_o = 17'(CV_W_LEN);
      T_CV_B:  len_o = 17'(CV_B_LEN);
      default: len_o = '0;
    endcase
  end

  always_comb begin
    next_o = SEG_END;
    for (int i = 5; i >= 0; i--) begin
      if (3'(i) > seg_i && LENS[i] != 0) begin
        next_o = 3'(i);
      end
    end
  end

  assign zero_o = (len_o == '0);

endmodule

// File: rtl/lstm_init_sequencer.sv
// Streams the six parameter segments into the LSTM core, then
// hands X vectors to the core and returns H results.
module lstm_init_sequencer
  import lstm_pkg::*;
#(
  parameter int unsigned SYS_W_LEN  = DEF_SYS_W_LEN,
  parameter int unsigned SYS_B_LEN  = DEF_SYS_B_LEN,
  parameter int unsigned BR_W_LEN   = DEF_BR_W_LEN,
  parameter int unsigned BR_B_LEN   = DEF_BR_B_LEN,
  parameter int unsigned CV_W_LEN   = DEF_CV_W_LEN,
  parameter int unsigned CV_B_LEN   = DEF_CV_B_LEN,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int          XH_W       = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            mem_req,
  output logic [2:0]      mem_seg,
  output logic [15:0]     mem_addr,
  input  logic            mem_rvalid,
  input  logic [7:0]      mem_rdata,
  output logic            init_valid,
  output logic [2:0]      init_type,
  output logic [7:0]      init_data,
  output logic            cfg_done,
  input  logic            x_valid,
  output logic            x_ready,
  input  logic [XH_W-1:0] x_data,
  output logic            next_valid,
  output logic [XH_W-1:0] next_data,
  input  logic            lstm_done,
  input  logic [XH_W-1:0] lstm_h,
  output logic            h_valid,
  input  logic            h_ready,
  output logic [XH_W-1:0] h_data
);

  localparam logic [15:0] GAP_LAST =
    16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_e          state_q, state_d;
  logic [2:0]      seg_q, seg_d;
  logic [15:0]     addr_q, addr_d;
  logic [15:0]     gap_q, gap_d;
  logic [2:0]      wd_q, wd_d;
  logic [7:0]      byte_q, byte_d;
  logic [XH_W-1:0] nxt_q, nxt_d;
  logic [XH_W-1:0] h_q, h_d;
  logic            req_q, req_d;
  logic            iv_q, iv_d;
  logic [2:0]      it_q, it_d;
  logic            cfg_q, cfg_d;
  logic            xr_q, xr_d;
  logic            nv_q, nv_d;
  logic            hv_q, hv_d;

  logic [16:0]     seg_len;
  logic            seg_zero;
  logic [2:0]      next_seg;

  seg_len_rom #(
    .SYS_W_LEN (SYS_W_LEN),
    .SYS_B_LEN (SYS_B_LEN),
    .BR_W_LEN  (BR_W_LEN),
    .BR_B_LEN  (BR_B_LEN),
    .CV_W_LEN  (CV_W_LEN),
    .CV_B_LEN  (CV_B_LEN)
  ) u_rom (
    .seg_i  (seg_q),
    .len_o  (seg_len),
    .zero_o (seg_zero),
    .next_o (next_seg)
  );

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    wd_d    = wd_q;
    byte_d  = byte_q;
    nxt_d   = nxt_q;
    h_d     = h_q;
    unique case (state_q)
      S_IDLE: begin
        // seg_q is always 0 here: IDLE is reached only through reset.
        if (start) begin
          seg_d   = seg_zero ? next_seg : seg_q;
          addr_d  = '0;
          state_d = (seg_d == SEG_END) ? S_RUN : S_REQ;
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rvalid) begin
          byte_d  = mem_rdata;
          state_d = S_PUSH;
        end
      end
      S_PUSH: begin
        if ({1'b0, addr_q} != seg_len - 17'd1) begin
          addr_d  = addr_q + 16'd1;
          state_d = S_REQ;
        end else begin
          seg_d  = next_seg;
          addr_d = '0;
          gap_d  = '0;
          if (GAP_CYCLES == 0) begin
            state_d = (next_seg == SEG_END) ? S_RUN : S_REQ;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = (seg_q == SEG_END) ? S_RUN : S_REQ;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      S_RUN: begin
        if (x_valid && xr_q) begin
          nxt_d   = x_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        if (!lstm_done) begin
          state_d = S_DONE;
        end else if (wd_q == RETRY_LAST) begin
          state_d = S_ISSUE;
        end else begin
          wd_d = wd_q + 3'd1;
        end
      end
      S_DONE: begin
        if (lstm_done) begin
          h_d     = lstm_h;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (h_ready) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase

    req_d = (state_d == S_REQ);
    iv_d  = (state_d == S_PUSH);
    it_d  = (state_d == S_PUSH) ? seg_q : T_IDLE;
    cfg_d = cfg_q | (state_d == S_RUN);
    xr_d  = (state_d == S_RUN) & lstm_done;
    nv_d  = (state_d == S_ISSUE);
    hv_d  = (state_d == S_OUT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      seg_q   <= '0;
      addr_q  <= '0;
      gap_q   <= '0;
      wd_q    <= '0;
      byte_q  <= '0;
      nxt_q   <= '0;
      h_q     <= '0;
      req_q   <= 1'b0;
      iv_q    <= 1'b0;
      it_q    <= T_IDLE;
      cfg_q   <= 1'b0;
      xr_q    <= 1'b0;
      nv_q    <= 1'b0;
      hv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      addr_q  <= addr_d;
      gap_q   <= gap_d;
      wd_q    <= wd_d;
      byte_q  <= byte_d;
      nxt_q   <= nxt_d;
      h_q     <= h_d;
      req_q   <= req_d;
      iv_q    <= iv_d;
      it_q    <= it_d;
      cfg_q   <= cfg_d;
      xr_q    <= xr_d;
      nv_q    <= nv_d;
      hv_q    <= hv_d;
    end
  end

  assign mem_req    = req_q;
  assign mem_seg    = seg_q;
  assign mem_addr   = addr_q;
  assign init_valid = iv_q;
  assign init_type  = it_q;
  assign init_data  = byte_q;
  assign cfg_done   = cfg_q;
  assign x_ready    = xr_q;
  assign next_valid = nv_q;
  assign next_data  = nxt_q;
  assign h_valid    = hv_q;
  assign h_data     = h_q;

endmodule

// File: tb/tb_lstm_init_sequencer.sv
// Self-checking bench: memory and core models, a spec-level
// expected-stream model and a per-cycle compare process.
module tb_lstm_init_sequencer;

  localparam int L [6] = '{6, 3, 0, 4, 5, 2};
  localparam int GAP = 2;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mem_req;
  logic [2:0]  mem_seg;
  logic [15:0] mem_addr;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        init_valid;
  logic [2:0]  init_type;
  logic [7:0]  init_data;
  logic        cfg_done;
  logic        x_valid;
  logic        x_ready;
  logic [63:0] x_data;
  logic        next_valid;
  logic [63:0] next_data;
  logic        lstm_done;
  logic [63:0] lstm_h;
  logic        h_valid;
  logic        h_ready;
  logic [63:0] h_data;

  lstm_init_sequencer #(
    .SYS_W_LEN  (6),
    .SYS_B_LEN  (3),
    .BR_W_LEN   (0),
    .BR_B_LEN   (4),
    .CV_W_LEN   (5),
    .CV_B_LEN   (2),
    .GAP_CYCLES (GAP),
    .XH_W       (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_req    (mem_req),
    .mem_seg    (mem_seg),
    .mem_addr   (mem_addr),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .init_valid (init_valid),
    .init_type  (init_type),
    .init_data  (init_data),
    .cfg_done   (cfg_done),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_data     (x_data),
    .next_valid (next_valid),
    .next_data  (next_data),
    .lstm_done  (lstm_done),
    .lstm_h     (lstm_h),
    .h_valid    (h_valid),
    .h_ready    (h_ready),
    .h_data     (h_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  bit stall = 1'b0;
  int ign_req = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] mem_byte(input int s, input int a);
    int v;
    v = s * 41 + a * 7 + 3;
    return v[7:0];
  endfunction

  function automatic logic [63:0] x_vec(input int i);
    return 64'h1111_1111_1111_1111 * 64'(i + 1);
  endfunction

  function automatic logic [63:0] core_fn(input logic [63:0] x);
    return ~x;
  endfunction

  // Memory: one outstanding read, latency lat plus optional stall
  initial begin
    int cnt, pseg, paddr;
    bit pend;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    pend = 1'b0;
    cnt = 0; pseg = 0; paddr = 0;
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_rdata = 8'($urandom);
      if (reset) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata = mem_byte(pseg, paddr);
            pend = 1'b0;
          end
        end
        if (mem_req) begin
          pend = 1'b1;
          pseg = int'(mem_seg);
          paddr = int'(mem_addr);
          cnt = lat + (stall ? int'($urandom_range(0, 3)) : 0);
        end
      end
    end
  end

  // Core: done falls 1 cycle after next, rises 20 cycles later
  initial begin
    int fall, rise, ign_taken;
    bit hold;
    logic [63:0] xl;
    lstm_done = 1'b1;
    lstm_h = '0;
    fall = 0; rise = 0; ign_taken = 0;
    hold = 1'b0;
    xl = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        lstm_done = 1'b1;
        fall = 0; rise = 0;
        hold = 1'b0;
      end else begin
        if (fall > 0) begin
          fall--;
          if (fall == 0) begin
            lstm_done = 1'b0;
            rise = 20;
          end
        end else if (rise > 0) begin
          rise--;
          if (rise == 0) begin
            lstm_done = 1'b1;
            lstm_h = core_fn(xl);
            hold = 1'b1;
          end
        end else if (hold) begin
          hold = 1'b0;
          lstm_h = {$urandom, $urandom};
        end
        if (next_valid && lstm_done && fall == 0 && rise == 0) begin
          xl = next_data;
          if (ign_req > ign_taken) ign_taken++;
          else fall = 1;
        end
      end
    end
  end

  typedef struct {
    int seg;
    int addr;
  } byte_t;

  byte_t q[$];
  int vec_idx = 0;

  // Compare process: samples just before each rising edge
  initial begin
    byte_t e;
    int cyc, last_cyc, last_seg, npulse, last_nv;
    bit have_last, prev_cfg;
    cyc = 0; last_cyc = 0; last_seg = 0;
    npulse = 0; last_nv = 0;
    have_last = 1'b0;
    prev_cfg = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        q.delete();
        for (int s = 0; s < 6; s++)
          for (int a = 0; a < L[s]; a++)
            q.push_back('{s, a});
        have_last = 1'b0;
        prev_cfg = 1'b0;
        vec_idx = 0;
        npulse = 0;
        cyc = 0;
      end else begin
        cyc++;
        if (mem_req) begin
          if (q.size() == 0) begin
            chk("mem_req_extra", 64'(mem_req), 64'(0));
          end else begin
            chk("mem_seg", 64'(mem_seg), 64'(q[0].seg));
            chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
          end
        end
        if (init_valid) begin
          if (q.size() == 0) begin
            chk("init_extra", 64'(init_valid), 64'(0));
          end else begin
            e = q.pop_front();
            chk("init_type", 64'(init_type), 64'(e.seg));
            chk("init_data", 64'(init_data),
                64'(mem_byte(e.seg, e.addr)));
            if (lat == 1 && !stall && have_last)
              chk("init_spacing", 64'(cyc - last_cyc),
                  64'((e.seg != last_seg) ? 3 + GAP : 3));
            have_last = 1'b1;
            last_cyc = cyc;
            last_seg = e.seg;
          end
        end else begin
          chk("idle_type", 64'(init_type), 64'(7));
        end
        if (cfg_done && !prev_cfg)
          chk("load_complete", 64'(q.size()), 64'(0));
        if (prev_cfg)
          chk("cfg_sticky", 64'(cfg_done), 64'(1));
        prev_cfg = cfg_done;
        if (next_valid) begin
          chk("next_data", next_data, x_vec(vec_idx));
          if (npulse > 0)
            chk("repulse_gap", 64'(cyc - last_nv), 64'(8));
          npulse++;
          last_nv = cyc;
        end
        if (h_valid) begin
          chk("h_data", h_data, core_fn(x_vec(vec_idx)));
          if (h_ready) begin
            chk("pulses_per_vec", 64'(npulse),
                64'((vec_idx == 10) ? 2 : 1));
            vec_idx++;
            npulse = 0;
          end
        end
        if (x_ready)
          chk("x_ready_excl", 64'({h_valid, next_valid, cfg_done}),
              64'(3'b001));
      end
    end
  end

  task automatic check_rst(input string nm);
    logic [35:0] act, exp;
    act = {mem_req, mem_seg, mem_addr, init_valid, init_type,
           init_data, cfg_done, x_ready, next_valid, h_valid};
    exp = {1'b0, 3'd0, 16'd0, 1'b0, 3'd7,
           8'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    chk({nm, "_ctl"}, 64'(act), 64'(exp));
    chk({nm, "_next"}, next_data, 64'(0));
    chk({nm, "_h"}, h_data, 64'(0));
  endtask

  task automatic pulse_reset(input string nm);
    reset = 1'b1;
    #1;
    check_rst(nm);
    @(negedge clk);
    @(negedge clk);
    check_rst({nm, "_held"});
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_load(input bit chk_lat);
    int cnt;
    bit seen;
    seen = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    chk("first_req", 64'({mem_req, mem_seg, mem_addr}),
        64'({1'b1, 3'd0, 16'd0}));
    while (!cfg_done && cnt < 5000) begin
      @(negedge clk);
      cnt++;
      if (chk_lat && init_valid && !seen) begin
        seen = 1'b1;
        chk("first_byte", 64'({init_type, init_data}),
            64'({3'd0, 8'd3}));
      end
    end
    if (!cfg_done) chk("load_timeout", 64'(cnt), 64'(0));
    else if (chk_lat) chk("load_latency", 64'(cnt), 64'(71));
  endtask

  task automatic run_vec(input int i, input int hold);
    int n;
    if (hold > 0) h_ready = 1'b0;
    x_data = x_vec(i);
    x_valid = 1'b1;
    n = 0;
    while (!x_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!x_ready) chk("x_accept_timeout", 64'(n), 64'(0));
    @(negedge clk);
    x_valid = 1'b0;
    chk("x_to_next", 64'(next_valid), 64'(1));
    n = 0;
    while (!h_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!h_valid) chk("h_timeout", 64'(n), 64'(0));
    if (i == 0) chk("h0_literal", h_data, 64'hEEEE_EEEE_EEEE_EEEE);
    repeat (hold) @(negedge clk);
    if (hold > 0) chk("h_held", 64'(h_valid), 64'(1));
    h_ready = 1'b1;
    @(negedge clk);
    chk("h_released", 64'(h_valid), 64'(0));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    start = 1'b0;
    x_valid = 1'b0;
    x_data = '0;
    h_ready = 1'b1;
    repeat (3) @(negedge clk);
    check_rst("rst_init");
    reset = 1'b0;
    @(negedge clk);

    lat = 1;
    stall = 1'b0;
    do_load(1'b1);

    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      run_vec(i, (i == 3) ? 5 : 0);
    end
    ign_req++;
    run_vec(10, 0);
    chk("vectors_done", 64'(vec_idx), 64'(11));

    pulse_reset("rst_after_run");

    lat = 4;
    stall = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(mem_req && mem_seg == 3'd4 && mem_addr == 16'd2)
           && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("midload_timeout", 64'(n), 64'(0));
    pulse_reset("rst_midload");

    do_load(1'b0);
    chk("reload_cfg", 64'(cfg_done), 64'(1));

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
